ultrasonic_trig_seq: RTL and testbench
======================================

ULTRASONIC_TRIG_SEQ -- requirements
Module: ultrasonic_trig_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of ultrasonic sensor channels (1..16).
REQ-002 SHALL have parameter TRIG_CYCLES, default 500: trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_900_000: maximum echo wait per slot, counted from slot start (38 ms).
REQ-004 SHALL have parameter PERIOD_CYCLES, default 3_000_000: slot length per channel (60 ms); legal only if TRIG_CYCLES < TIMEOUT_CYCLES < PERIOD_CYCLES.
REQ-005 SHALL have parameter ECHO_W, default 22: width of the echo measurement result.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  run ranging sequence while high.
REQ-009 ch_mask  input  NUM_CH  channel enables; bit i=1 includes channel i in the rotation.
REQ-010 echo  input  NUM_CH  asynchronous echo lines from the sensors.
REQ-011 trig  output  NUM_CH  registered trigger pulses, at most one bit high at a time.
REQ-012 meas_valid  output  1  one-cycle strobe: result fields valid.
REQ-013 meas_ch  output  max(1,clog2(NUM_CH))  channel index of the result.
REQ-014 meas_width  output  ECHO_W  echo high time in clk cycles.
REQ-015 meas_timeout  output  1  result ended by timeout, not echo fall.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Each echo bit SHALL pass a 2-flop synchronizer; all echo decisions use the synchronized value echo_s.
REQ-018 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
REQ-019 IDLE: when enable=1 and ch_mask!=0, SHALL select the first set mask bit at or after rr_ptr (wrapping), latch it as cur_ch, clear slot_cnt, and enter TRIG next cycle; with ch_mask=0, SHALL stay in IDLE.
REQ-020 slot_cnt SHALL be 0 on the first TRIG cycle and increment by 1 every cycle of the slot.
REQ-021 TRIG: trig[cur_ch] SHALL be high for exactly TRIG_CYCLES consecutive cycles, then go to WAIT_RISE.
REQ-022 WAIT_RISE: a 0->1 transition of echo_s[cur_ch] SHALL enter MEASURE with width_cnt=1.
REQ-023 MEASURE: width_cnt SHALL increment each cycle echo_s[cur_ch]=1, saturating at 2^ECHO_W-1.
REQ-024 MEASURE: the first cycle echo_s[cur_ch]=0 SHALL pulse meas_valid with meas_width=width_cnt, meas_timeout=0, then enter GAP.
REQ-025 In WAIT_RISE or MEASURE, when slot_cnt==TIMEOUT_CYCLES-1 and no result has been emitted, SHALL pulse meas_valid with meas_timeout=1 and meas_width=width_cnt (0 if no rise), then enter GAP.
REQ-026 If an echo fall and the timeout occur in the same cycle, the echo fall SHALL win (meas_timeout=0).
REQ-027 Exactly one meas_valid pulse SHALL be issued per slot; there is no backpressure.
REQ-028 meas_ch/meas_width/meas_timeout SHALL hold their values until the next meas_valid.
REQ-029 GAP: at slot_cnt==PERIOD_CYCLES-1, SHALL set rr_ptr=cur_ch+1 (mod NUM_CH); if enable=1 and ch_mask!=0, SHALL start the next slot directly (TRIG, next channel per REQ-019); otherwise SHALL return to IDLE.
REQ-030 ch_mask SHALL be sampled only at slot start; mask changes mid-slot do not abort the slot.
REQ-031 Deasserting enable mid-slot SHALL let the current slot finish through GAP.
REQ-032 Echo activity on channels other than cur_ch SHALL be ignored.

Reset
REQ-033 On reset: state=IDLE, trig=0, meas_valid=0, meas_ch=0, meas_width=0, meas_timeout=0, busy=0, rr_ptr=0, counters and synchronizers cleared; applies mid-operation, taking effect on the next edge.

Verification (NUM_CH=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=40, PERIOD_CYCLES=64, ECHO_W=8)
REQ-034 enable=1, mask=4'b1111, echo[0] high 10 cycles starting 5 cycles after trig falls -> trig[0] high 4 cycles; meas_valid once, meas_ch=0, meas_width=10, meas_timeout=0; trig[1] rises 64 cycles after trig[0] rose.
REQ-035 mask=4'b1010, no echo -> slots alternate ch1, ch3, ch1; each gives meas_timeout=1, meas_width=0 at slot_cnt 39.
REQ-036 echo[cur_ch] rises, stays high past timeout -> meas_timeout=1, meas_width equals high cycles counted through slot_cnt 39.
REQ-037 echo falls on the exact timeout cycle -> meas_timeout=0, single meas_valid.
REQ-038 reset asserted during MEASURE -> next cycle trig=0, busy=0, meas_valid=0; after release with enable=1 sequence restarts at channel 0.
REQ-039 enable dropped in TRIG of ch2 -> ch2 slot completes with one result, then IDLE, busy=0, no further trig.

Source files
------------

// File: rtl/ultrasonic_trig_seq.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_trig_seq
// Function : Round-robin trigger/echo ranging sequencer for ultrasonic sensors.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_trig_seq #(
  parameter int  NUM_CH         = 4,
  parameter int  TRIG_CYCLES    = 500,
  parameter int  TIMEOUT_CYCLES = 1_900_000,
  parameter int  PERIOD_CYCLES  = 3_000_000,
  parameter int  ECHO_W         = 22,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trig,
  output logic              meas_valid,
  output logic [CH_W-1:0]   meas_ch,
  output logic [ECHO_W-1:0] meas_width,
  output logic              meas_timeout,
  output logic              busy
);

  localparam int SLOT_W = $clog2(PERIOD_CYCLES);

  localparam logic [SLOT_W-1:0] c_TRIG_LAST    = SLOT_W'(TRIG_CYCLES - 1);
  localparam logic [SLOT_W-1:0] c_TIMEOUT_LAST = SLOT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] c_PERIOD_LAST  = SLOT_W'(PERIOD_CYCLES - 1);
  localparam logic [CH_W-1:0]   c_CH_LAST      = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]     c_NUM_CH       = (CH_W + 1)'(NUM_CH);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_TRIG      = 3'd1;
  localparam logic [2:0] c_WAIT_RISE = 3'd2;
  localparam logic [2:0] c_MEASURE   = 3'd3;
  localparam logic [2:0] c_GAP       = 3'd4;

  logic [2:0]          r_state;
  logic [NUM_CH-1:0]   r_echo_m;
  logic [NUM_CH-1:0]   r_echo_s;
  logic [NUM_CH-1:0]   r_echo_d;
  logic [NUM_CH-1:0]   r_trig;
  logic [CH_W-1:0]     r_cur_ch;
  logic [CH_W-1:0]     r_rr_ptr;
  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [ECHO_W-1:0]   r_width_cnt;
  logic                r_meas_valid;
  logic [CH_W-1:0]     r_meas_ch;
  logic [ECHO_W-1:0]   r_meas_width;
  logic                r_meas_timeout;

  logic                w_start;
  logic [CH_W-1:0]     w_next_ch;
  logic [CH_W-1:0]     w_sel_base;
  logic [2*NUM_CH-1:0] w_mask2;
  logic [NUM_CH-1:0]   w_rot;
  logic [CH_W-1:0]     w_off;
  logic [CH_W:0]       w_sel_sum;
  logic [CH_W-1:0]     w_sel_ch;
  logic [NUM_CH-1:0]   w_sel_onehot;
  logic                w_echo_cur;
  logic                w_rise;
  logic                w_timeout;
  logic                w_period_end;
  logic [ECHO_W-1:0]   w_width_inc;

  assign w_start   = enable & (|ch_mask);
  assign w_next_ch = (r_cur_ch == c_CH_LAST) ? '0 : r_cur_ch + 1'b1;

  // At the end of GAP the search must already start after the finishing
  // channel, since r_rr_ptr is only updated on that same edge.
  assign w_sel_base = (r_state == c_GAP) ? w_next_ch : r_rr_ptr;
  assign w_mask2    = {ch_mask, ch_mask};
  assign w_rot      = NUM_CH'(w_mask2 >> w_sel_base);

  always_comb begin
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = CH_W'(i);
      end
    end
  end

  assign w_sel_sum    = {1'b0, w_sel_base} + {1'b0, w_off};
  assign w_sel_ch     = (w_sel_sum >= c_NUM_CH) ? CH_W'(w_sel_sum - c_NUM_CH)
                                                : w_sel_sum[CH_W-1:0];
  assign w_sel_onehot = NUM_CH'(1) << w_sel_ch;

  assign w_echo_cur   = r_echo_s[r_cur_ch];
  assign w_rise       = w_echo_cur & ~r_echo_d[r_cur_ch];
  assign w_timeout    = (r_slot_cnt == c_TIMEOUT_LAST);
  assign w_period_end = (r_slot_cnt == c_PERIOD_LAST);
  assign w_width_inc  = (&r_width_cnt) ? r_width_cnt : r_width_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_IDLE;
      r_echo_m       <= '0;
      r_echo_s       <= '0;
      r_echo_d       <= '0;
      r_trig         <= '0;
      r_cur_ch       <= '0;
      r_rr_ptr       <= '0;
      r_slot_cnt     <= '0;
      r_width_cnt    <= '0;
      r_meas_valid   <= 1'b0;
      r_meas_ch      <= '0;
      r_meas_width   <= '0;
      r_meas_timeout <= 1'b0;
    end else begin
      r_echo_m     <= echo;
      r_echo_s     <= r_echo_m;
      r_echo_d     <= r_echo_s;
      r_meas_valid <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_cur_ch    <= w_sel_ch;
            r_slot_cnt  <= '0;
            r_width_cnt <= '0;
            r_trig      <= w_sel_onehot;
            r_state     <= c_TRIG;
          end
        end

        c_TRIG: begin
          r_slot_cnt <= r_slot_cnt + 1'b1;
          if (r_slot_cnt == c_TRIG_LAST) begin
            r_trig  <= '0;
            r_state <= c_WAIT_RISE;
          end
        end

        c_WAIT_RISE: begin
          r_slot_cnt <= r_slot_cnt + 1'b1;
          if (w_rise) begin
            r_width_cnt <= ECHO_W'(1);
            if (w_timeout) begin
              // Rise on the last wait cycle: one high cycle already counted.
              r_meas_valid   <= 1'b1;
              r_meas_ch      <= r_cur_ch;
              r_meas_width   <= ECHO_W'(1);
              r_meas_timeout <= 1'b1;
              r_state        <= c_GAP;
            end else begin
              r_state <= c_MEASURE;
            end
          end else if (w_timeout) begin
            r_meas_valid   <= 1'b1;
            r_meas_ch      <= r_cur_ch;
            r_meas_width   <= '0;
            r_meas_timeout <= 1'b1;
            r_state        <= c_GAP;
          end
        end

        c_MEASURE: begin
          r_slot_cnt <= r_slot_cnt + 1'b1;
          if (!w_echo_cur) begin
            // The fall is checked first so it wins over a coincident timeout.
            r_meas_valid   <= 1'b1;
            r_meas_ch      <= r_cur_ch;
            r_meas_width   <= r_width_cnt;
            r_meas_timeout <= 1'b0;
            r_state        <= c_GAP;
          end else begin
            r_width_cnt <= w_width_inc;
            if (w_timeout) begin
              r_meas_valid   <= 1'b1;
              r_meas_ch      <= r_cur_ch;
              r_meas_width   <= w_width_inc;
              r_meas_timeout <= 1'b1;
              r_state        <= c_GAP;
            end
          end
        end

        c_GAP: begin
          if (w_period_end) begin
            r_rr_ptr <= w_next_ch;
            if (w_start) begin
              r_cur_ch    <= w_sel_ch;
              r_slot_cnt  <= '0;
              r_width_cnt <= '0;
              r_trig      <= w_sel_onehot;
              r_state     <= c_TRIG;
            end else begin
              r_slot_cnt <= '0;
              r_state    <= c_IDLE;
            end
          end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
          end
        end

        default: begin
          r_trig  <= '0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign trig         = r_trig;
  assign meas_valid   = r_meas_valid;
  assign meas_ch      = r_meas_ch;
  assign meas_width   = r_meas_width;
  assign meas_timeout = r_meas_timeout;
  assign busy         = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_trig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_trig_seq
// Function : Scoreboard bench for ultrasonic_trig_seq with a slot-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_trig_seq;

  localparam int NUM_CH         = 4;
  localparam int TRIG_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 40;
  localparam int PERIOD_CYCLES  = 64;
  localparam int ECHO_W         = 8;
  localparam int SYNC_DLY       = 2;
  localparam int T_LAST         = TIMEOUT_CYCLES - 1;

  logic              clk    = 1'b0;
  logic              reset  = 1'b1;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH-1:0] echo    = '0;
  logic [NUM_CH-1:0] trig;
  logic              meas_valid;
  logic [1:0]        meas_ch;
  logic [ECHO_W-1:0] meas_width;
  logic              meas_timeout;
  logic              busy;

  ultrasonic_trig_seq #(
    .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .PERIOD_CYCLES(PERIOD_CYCLES), .ECHO_W(ECHO_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .echo(echo),
    .trig(trig), .meas_valid(meas_valid), .meas_ch(meas_ch), .meas_width(meas_width),
    .meas_timeout(meas_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int width; int to; int cyc; } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int slot_cyc = -1;
  int rr       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round robin: first enabled channel at or after the pointer, wrapping.
  function automatic int pick_ch(input logic [3:0] m, input int base);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m[(base + i) % NUM_CH]) return (base + i) % NUM_CH;
    end
    return -1;
  endfunction

  // Echo input high for slot cycles [a,b); seen by the sequencer SYNC_DLY later.
  function automatic exp_t predict(input int ch, input int a, input int b);
    exp_t e;
    int   rs;
    int   fs;
    rs   = a + SYNC_DLY;
    fs   = b + SYNC_DLY;
    e.ch = ch;
    if (a == b || rs > T_LAST) begin
      e.width = 0; e.to = 1; e.cyc = T_LAST + 1;
    end else if (fs <= T_LAST) begin
      e.width = b - a; e.to = 0; e.cyc = fs + 1;
    end else begin
      e.width = T_LAST - rs + 1; e.to = 1; e.cyc = T_LAST + 1;
    end
    return e;
  endfunction

  task automatic run_slot(input int a, input int b, input logic [3:0] new_mask,
                          input int mask_cyc, input int drop_cyc, input bit push,
                          input int n_cyc);
    int         ch;
    logic [3:0] oh;
    logic [3:0] n;
    ch = pick_ch(ch_mask, rr);
    oh = 4'b0001 << ch;
    if (push) sb.push_back(predict(ch, a, b));
    rr = (ch + 1) % NUM_CH;
    for (int c = 0; c < n_cyc; c++) begin
      slot_cyc = c;
      n = (c < 52) ? 4'($urandom) : 4'b0000;
      n[ch] = (c >= a && c < b);
      echo = n;
      if (c == mask_cyc) ch_mask = new_mask;
      if (c == drop_cyc) enable = 1'b0;
      @(negedge clk);
      check("trig", trig, (c < TRIG_CYCLES) ? oh : 4'b0000);
      check("busy_slot", busy, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      slot_cyc = -1;
      echo     = '0;
      @(negedge clk);
      check("trig_idle", trig, 0);
      check("busy_idle", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_plan(output int a, output int b);
    case ($urandom_range(0, 5))
      0: begin a = 0; b = 0; end
      1: begin a = $urandom_range(2, 30); b = a + $urandom_range(1, 37 - a); end
      2: begin a = $urandom_range(2, 37); b = $urandom_range(38, 58); end
      3: begin a = $urandom_range(2, 36); b = 37; end
      4: begin a = $urandom_range(38, 50); b = a + $urandom_range(1, 8); end
      default: begin a = 37; b = $urandom_range(38, 45); end
    endcase
  endtask

  // Result monitor: pops the scoreboard on each strobe, checks hold otherwise.
  exp_t mon_e;
  int   hold_ch = 0;
  int   hold_w  = 0;
  int   hold_to = 0;
  always @(negedge clk) begin
    if (reset) begin
      hold_ch = 0; hold_w = 0; hold_to = 0;
    end else if (meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL meas_unexpected: got meas_valid=1 at slot cycle %0d expected none", slot_cyc);
      end else begin
        mon_e = sb.pop_front();
        check("meas_ch", meas_ch, mon_e.ch);
        check("meas_width", meas_width, mon_e.width);
        check("meas_timeout", meas_timeout, mon_e.to);
        check("meas_cycle", slot_cyc, mon_e.cyc);
        hold_ch = mon_e.ch; hold_w = mon_e.width; hold_to = mon_e.to;
      end
    end else begin
      check("meas_valid_low", meas_valid, 0);
      check("hold_ch", meas_ch, hold_ch);
      check("hold_width", meas_width, hold_w);
      check("hold_timeout", meas_timeout, hold_to);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_ch", meas_ch, 0);
    check("rst_width", meas_width, 0);
    check("rst_timeout", meas_timeout, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    // Single clean echo on ch0, then alternate ch1/ch3 timeouts.
    ch_mask = 4'hF;
    enable  = 1'b1;
    @(posedge clk); #1;
    run_slot(9, 19, 4'b1010, 10, -1, 1, PERIOD_CYCLES);
    repeat (3) run_slot(0, 0, 4'b1010, -1, -1, 1, PERIOD_CYCLES);

    // Echo held past timeout, then a fall exactly on the timeout cycle.
    run_slot(6, 50, 4'hF, 10, -1, 1, PERIOD_CYCLES);
    run_slot(12, 37, 4'hF, -1, -1, 1, PERIOD_CYCLES);

    for (int s = 0; s < 40; s++) begin
      rand_plan(a, b);
      run_slot(a, b, 4'($urandom_range(1, 15)), 10, -1, 1, PERIOD_CYCLES);
    end

    // Steer to ch2, then drop enable during its trigger pulse.
    rand_plan(a, b);
    run_slot(a, b, 4'b0100, 10, -1, 1, PERIOD_CYCLES);
    run_slot(8, 20, 4'b0100, -1, 1, 1, PERIOD_CYCLES);
    idle_cycles(20);

    enable  = 1'b1;
    ch_mask = 4'b0000;
    idle_cycles(10);

    // Reset in the middle of a measurement, then restart from ch0.
    ch_mask = 4'hF;
    @(posedge clk); #1;
    run_slot(5, 30, 4'hF, -1, -1, 0, 15);
    reset = 1'b1;
    echo  = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_trig", trig, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", meas_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rr    = 0;
    @(posedge clk); #1;
    rand_plan(a, b);
    run_slot(a, b, 4'hF, -1, -1, 1, PERIOD_CYCLES);
    rand_plan(a, b);
    run_slot(a, b, 4'hF, -1, 1, 1, PERIOD_CYCLES);
    idle_cycles(5);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
